pll_rst_seq: RTL and testbench

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

---
 rtl/pll_seq_pkg.sv | 31 +++
 rtl/pll_fb_sync.sv | 23 ++
 rtl/pll_rst_seq.sv | 145 ++++++++++++++
 tb/tb_pll_rst_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default
// timing constants and a width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT,
    ST_CHECK,
    ST_RUN,
    ST_FAIL
  } pll_state_e;

  localparam int unsigned DEF_RST_HOLD_CYC  = 16;
  localparam int unsigned DEF_LOCK_WAIT_CYC = 1024;
  localparam int unsigned DEF_MON_WIN       = 64;
  localparam int unsigned DEF_MIN_EDGES     = 8;
  localparam int unsigned DEF_MAX_RETRY     = 3;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_fb_sync.sv
// Brings the PLL-domain feedback toggle into clk and emits a one-cycle pulse
// on every edge (rising or falling).
module pll_fb_sync (
  input  logic clk,
  input  logic resetn,
  input  logic fb_toggle,
  output logic fb_edge
);

  // [0],[1] form the synchronizer; [2] is the history flop for edge detection.
  logic [2:0] r_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], fb_toggle};
    end
  end

  assign fb_edge = r_sync[1] ^ r_sync[2];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for settle, verifies the
// feedback toggle rate, then releases system reset and keeps monitoring.
module pll_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYC  = DEF_RST_HOLD_CYC,
  parameter int unsigned LOCK_WAIT_CYC = DEF_LOCK_WAIT_CYC,
  parameter int unsigned MON_WIN       = DEF_MON_WIN,
  parameter int unsigned MIN_EDGES     = DEF_MIN_EDGES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
  localparam int unsigned RW = idx_w(MAX_RETRY + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          sw_restart,
  input  logic          fb_toggle,
  output logic          pll_reset,
  output logic          sys_resetn,
  output logic          pll_ok,
  output logic          fail,
  output logic [RW-1:0] retry_cnt
);

  localparam int unsigned CW = idx_w(max3(RST_HOLD_CYC, LOCK_WAIT_CYC, MON_WIN));
  localparam int unsigned EW = idx_w(MIN_EDGES + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(LOCK_WAIT_CYC - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(MON_WIN - 1);
  localparam logic [EW-1:0] EDGE_MAX  = EW'(MIN_EDGES);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  pll_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [EW-1:0] r_edges;
  logic [RW-1:0] r_retry;
  logic          r_pll_reset;
  logic          r_sys_resetn;
  logic          r_pll_ok;
  logic          r_fail;

  logic          w_fb_edge;
  logic          w_win_end;
  logic          w_pass;
  logic [EW-1:0] w_edges_nxt;

  pll_fb_sync u_fb_sync (
    .clk       (clk),
    .resetn    (resetn),
    .fb_toggle (fb_toggle),
    .fb_edge   (w_fb_edge)
  );

  // The window decision includes an edge arriving on the window's last cycle.
  always_comb begin
    w_edges_nxt = r_edges;
    if (w_fb_edge && (r_edges != EDGE_MAX)) begin
      w_edges_nxt = r_edges + EW'(1);
    end
    w_win_end = (r_cnt == WIN_LAST);
    w_pass    = (w_edges_nxt == EDGE_MAX);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_HOLD;
      r_cnt        <= '0;
      r_edges      <= '0;
      r_retry      <= '0;
      r_pll_reset  <= 1'b1;
      r_sys_resetn <= 1'b0;
      r_pll_ok     <= 1'b0;
      r_fail       <= 1'b0;
    end else if (sw_restart) begin
      r_state      <= ST_HOLD;
      r_cnt        <= '0;
      r_edges      <= '0;
      r_retry      <= '0;
      r_pll_reset  <= 1'b1;
      r_sys_resetn <= 1'b0;
      r_pll_ok     <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state     <= ST_WAIT;
            r_cnt       <= '0;
            r_pll_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          if (r_cnt == WAIT_LAST) begin
            r_state <= ST_CHECK;
            r_cnt   <= '0;
            r_edges <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // CHECK and RUN share the monitor window; only the failure path differs.
        ST_CHECK, ST_RUN: begin
          r_cnt   <= w_win_end ? '0 : r_cnt + CW'(1);
          r_edges <= w_win_end ? '0 : w_edges_nxt;
          if (w_win_end) begin
            if (w_pass) begin
              r_state      <= ST_RUN;
              r_sys_resetn <= 1'b1;
              r_pll_ok     <= 1'b1;
            end else if (r_state == ST_RUN) begin
              r_state      <= ST_HOLD;
              r_retry      <= '0;
              r_pll_reset  <= 1'b1;
              r_sys_resetn <= 1'b0;
              r_pll_ok     <= 1'b0;
            end else if (r_retry < RETRY_MAX) begin
              r_state     <= ST_HOLD;
              r_retry     <= r_retry + RW'(1);
              r_pll_reset <= 1'b1;
            end else begin
              r_state     <= ST_FAIL;
              r_pll_reset <= 1'b1;
              r_fail      <= 1'b1;
            end
          end
        end
        ST_FAIL: begin
          r_state <= ST_FAIL;
        end
        default: begin
          r_state <= ST_HOLD;
        end
      endcase
    end
  end

  assign pll_reset  = r_pll_reset;
  assign sys_resetn = r_sys_resetn;
  assign pll_ok     = r_pll_ok;
  assign fail       = r_fail;
  assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed scenarios plus randomized feedback traffic,
// checked each cycle against a timeline model built from edge history.
module tb_pll_rst_seq;

  localparam int unsigned HOLD  = 4;
  localparam int unsigned LWAIT = 8;
  localparam int unsigned WIN   = 16;
  localparam int unsigned MINE  = 4;
  localparam int unsigned MAXR  = 2;
  localparam int          TPASS = HOLD + LWAIT + WIN;
  localparam int          HMAX  = 8192;

  logic       clk        = 1'b0;
  logic       resetn     = 1'b1;
  logic       sw_restart = 1'b0;
  logic       fb_toggle  = 1'b0;
  logic       pll_reset;
  logic       sys_resetn;
  logic       pll_ok;
  logic       fail;
  logic [1:0] retry_cnt;

  pll_rst_seq #(
    .RST_HOLD_CYC  (HOLD),
    .LOCK_WAIT_CYC (LWAIT),
    .MON_WIN       (WIN),
    .MIN_EDGES     (MINE),
    .MAX_RETRY     (MAXR)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sw_restart (sw_restart),
    .fb_toggle  (fb_toggle),
    .pll_reset  (pll_reset),
    .sys_resetn (sys_resetn),
    .pll_ok     (pll_ok),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef enum {M_SEQ, M_RUN, M_FAIL} mode_e;
  mode_e       mode = M_SEQ;
  int          cyc = 0;
  int          rel = 0;
  int          seq_start = 0;
  int          run_start = 0;
  int unsigned retries = 0;
  bit          fbh [HMAX];

  // Feedback level the DUT sampled on edge i; flops are cleared by reset.
  function automatic bit fb_at(input int i);
    if (i <= rel || i < 0 || i >= HMAX) return 1'b0;
    return fbh[i];
  endfunction

  // An input change sampled on edge k is counted by the sequencer on edge k+2.
  function automatic int win_edges(input int n);
    int c;
    c = 0;
    for (int m = n - int'(WIN) + 1; m <= n; m++)
      if (fb_at(m - 2) != fb_at(m - 3)) c++;
    return c;
  endfunction

  function automatic logic [5:0] expv();
    int off;
    off = cyc - seq_start;
    case (mode)
      M_RUN:   return {1'b0, 1'b1, 1'b1, 1'b0, 2'(retries)};
      M_FAIL:  return {1'b1, 1'b0, 1'b0, 1'b1, 2'(retries)};
      default: return {(off < int'(HOLD)), 1'b0, 1'b0, 1'b0, 2'(retries)};
    endcase
  endfunction

  function automatic logic [5:0] obs();
    return {pll_reset, sys_resetn, pll_ok, fail, retry_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (cyc < HMAX) fbh[cyc] = fb_toggle;
    if (sw_restart) begin
      mode = M_SEQ; seq_start = cyc; retries = 0;
    end else if (mode == M_SEQ && (cyc - seq_start) == TPASS) begin
      if (win_edges(cyc) >= int'(MINE)) begin
        mode = M_RUN; run_start = cyc;
      end else if (retries < MAXR) begin
        retries++; seq_start = cyc;
      end else begin
        mode = M_FAIL;
      end
    end else if (mode == M_RUN && ((cyc - run_start) % int'(WIN)) == 0) begin
      if (win_edges(cyc) < int'(MINE)) begin
        mode = M_SEQ; seq_start = cyc; retries = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; sw_restart = 1'b0; fb_toggle = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    rel = cyc; mode = M_SEQ; seq_start = cyc; retries = 0;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #2;
    n_cmp++;
    if (obs() !== 6'b100000) begin
      n_bad++; $display("FAIL reset_values got=%b exp=%b", obs(), 6'b100000);
    end
  endtask

  task automatic test_nominal();
    int fall, rise;
    fall = -1; rise = -1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL nominal off=%0d got=%b exp=%b", cyc - rel, obs(), expv());
      end
      if (fall < 0 && !pll_reset) fall = cyc - rel;
      if (rise < 0 && sys_resetn) rise = cyc - rel;
      if (((cyc - rel) % 2) == 0) fb_toggle = ~fb_toggle;
    end
    n_cmp++;
    if (fall != int'(HOLD)) begin
      n_bad++; $display("FAIL nominal_pll_reset_fall got=%0d exp=%0d", fall, HOLD);
    end
    n_cmp++;
    if (rise != TPASS) begin
      n_bad++; $display("FAIL nominal_sys_resetn_rise got=%0d exp=%0d", rise, TPASS);
    end
    n_cmp++;
    if ({fail, retry_cnt, pll_ok} !== 4'b0001) begin
      n_bad++; $display("FAIL nominal_flags got=%b exp=0001", {fail, retry_cnt, pll_ok});
    end
  endtask

  task automatic test_stuck();
    int r1, r2, ff;
    r1 = -1; r2 = -1; ff = -1;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL stuck off=%0d got=%b exp=%b", cyc - rel, obs(), expv());
      end
      if (r1 < 0 && retry_cnt == 2'd1) r1 = cyc - rel;
      if (r2 < 0 && retry_cnt == 2'd2) r2 = cyc - rel;
      if (ff < 0 && fail) ff = cyc - rel;
    end
    n_cmp++;
    if (r1 != 28 || r2 != 56) begin
      n_bad++; $display("FAIL stuck_retry_times got=%0d,%0d exp=28,56", r1, r2);
    end
    n_cmp++;
    if (ff != 84) begin
      n_bad++; $display("FAIL stuck_fail_time got=%0d exp=84", ff);
    end
    n_cmp++;
    if ({pll_reset, sys_resetn, fail} !== 3'b101) begin
      n_bad++; $display("FAIL stuck_hold_outputs got=%b exp=101", {pll_reset, sys_resetn, fail});
    end
  endtask

  task automatic test_restart_from_fail();
    int entry, rise, per;
    rise = -1; per = int'($urandom_range(1, 3));
    do_reset();
    for (int i = 0; i < 86; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL restart_pre off=%0d got=%b exp=%b", cyc - rel, obs(), expv());
      end
    end
    sw_restart = 1'b1;
    tick();
    entry = cyc;
    sw_restart = 1'b0;
    n_cmp++;
    if ({fail, retry_cnt, pll_reset} !== 4'b0001) begin
      n_bad++; $display("FAIL restart_clear got=%b exp=0001", {fail, retry_cnt, pll_reset});
    end
    for (int i = 0; i < 32; i++) begin
      if (((cyc - entry) % per) == 0) fb_toggle = ~fb_toggle;
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL restart off=%0d got=%b exp=%b", cyc - entry, obs(), expv());
      end
      if (rise < 0 && sys_resetn) rise = cyc - entry;
    end
    n_cmp++;
    if (rise != TPASS) begin
      n_bad++; $display("FAIL restart_rise got=%0d exp=%0d", rise, TPASS);
    end
  endtask

  task automatic test_run_loss();
    int per, stop, lost, rise;
    logic [1:0] loss_v;
    per = int'($urandom_range(1, 3)); lost = -1; rise = -1; loss_v = 2'b00;
    do_reset();
    for (int i = 0; i < TPASS; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL loss_pre off=%0d got=%b exp=%b", cyc - rel, obs(), expv());
      end
      if (((cyc - rel) % per) == 0) fb_toggle = ~fb_toggle;
    end
    stop = cyc;
    for (int i = 0; i < 80; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL loss off=%0d got=%b exp=%b", cyc - stop, obs(), expv());
      end
      if (lost < 0 && !sys_resetn) begin
        lost = cyc; loss_v = {pll_reset, pll_ok};
      end else if (lost >= 0 && rise < 0 && sys_resetn) begin
        rise = cyc;
      end
      if (lost >= 0 && ((cyc - lost) % per) == 0) fb_toggle = ~fb_toggle;
    end
    n_cmp++;
    if (lost < 0 || (lost - stop) > 2 * int'(WIN) || loss_v !== 2'b10) begin
      n_bad++; $display("FAIL loss_detect got=%0d cyc,%b exp<=32,10", lost - stop, loss_v);
    end
    n_cmp++;
    if (lost < 0 || (rise - lost) != TPASS) begin
      n_bad++; $display("FAIL loss_recover got=%0d exp=%0d", rise - lost, TPASS);
    end
  endtask

  task automatic test_edge_count();
    logic [2:0] at_end;
    for (int k = 3; k <= 4; k++) begin
      at_end = 3'b111;
      do_reset();
      for (int i = 0; i < 30; i++) begin
        int off;
        tick();
        off = cyc - rel;
        n_cmp++;
        if (obs() !== expv()) begin
          n_bad++; $display("FAIL edges%0d off=%0d got=%b exp=%b", k, off, obs(), expv());
        end
        if (off == TPASS) at_end = {retry_cnt, pll_ok};
        if (off >= 13 && off < 13 + 2 * k && ((off - 13) % 2) == 0) fb_toggle = ~fb_toggle;
      end
      n_cmp++;
      if (at_end !== ((k == 3) ? 3'b010 : 3'b001)) begin
        n_bad++; $display("FAIL edges%0d_decision got=%b exp=%b", k, at_end,
                          ((k == 3) ? 3'b010 : 3'b001));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int rise, per;
    rise = -1; per = int'($urandom_range(1, 3));
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL midwait_pre off=%0d got=%b exp=%b", cyc - rel, obs(), expv());
      end
      if (((cyc - rel) % per) == 0) fb_toggle = ~fb_toggle;
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 6'b100000) begin
      n_bad++; $display("FAIL midwait_async got=%b exp=%b", obs(), 6'b100000);
    end
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL midwait off=%0d got=%b exp=%b", cyc - rel, obs(), expv());
      end
      if (rise < 0 && sys_resetn) rise = cyc - rel;
      if (((cyc - rel) % per) == 0) fb_toggle = ~fb_toggle;
    end
    n_cmp++;
    if (rise != TPASS) begin
      n_bad++; $display("FAIL midwait_rise got=%0d exp=%0d", rise, TPASS);
    end
  endtask

  task automatic test_random();
    int unsigned prob;
    for (int ep = 0; ep < 4; ep++) begin
      prob = $urandom_range(0, 70);
      do_reset();
      for (int i = 0; i < 400; i++) begin
        tick();
        n_cmp++;
        if (obs() !== expv()) begin
          n_bad++; $display("FAIL random ep=%0d off=%0d got=%b exp=%b", ep, cyc - rel, obs(), expv());
        end
        sw_restart = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 99) < prob) fb_toggle = ~fb_toggle;
      end
      sw_restart = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_stuck();
    test_restart_from_fail();
    test_run_loss();
    test_edge_count();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
